// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, instruction field positions and reset values for the multicycle sequencer
package mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } mc_state_e;

    // Instruction word layout: {marker, opcode[7:0]}; opcode[3] = memory step, opcode[2:0] = last step.
    localparam int MC_MARK_BIT = 8;
    localparam int MC_MEM_BIT  = 3;
    localparam int MC_LAST_LSB = 0;
    localparam int MC_LAST_W   = 3;

    localparam logic [7:0] MC_OPCODE_RST = 8'h00;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - fetch/decode/memory signal bundle for the multicycle sequencer
// master: fetch + memory side (drives instr_valid, instr, mem_ready)
// slave : sequencer (drives multicycle_flag, mc_opcode, step, stall, mem_req, busy, done[, wdog_err])
// wdog_err exists only when MULTICYCLE_WATCHDOG_EN is defined.
interface multicycle_sequencer_if #(
    parameter int STEP_W = 3
);
    logic              instr_valid;
    logic [8:0]        instr;
    logic              mem_ready;
    logic              multicycle_flag;
    logic [7:0]        mc_opcode;
    logic [STEP_W-1:0] step;
    logic              stall;
    logic              mem_req;
    logic              busy;
    logic              done;
`ifdef MULTICYCLE_WATCHDOG_EN
    logic              wdog_err;

    modport master (output instr_valid, instr, mem_ready,
                    input  multicycle_flag, mc_opcode, step, stall, mem_req, busy, done, wdog_err);
    modport slave  (input  instr_valid, instr, mem_ready,
                    output multicycle_flag, mc_opcode, step, stall, mem_req, busy, done, wdog_err);
`else
    modport master (output instr_valid, instr, mem_ready,
                    input  multicycle_flag, mc_opcode, step, stall, mem_req, busy, done);
    modport slave  (input  instr_valid, instr, mem_ready,
                    output multicycle_flag, mc_opcode, step, stall, mem_req, busy, done);
`endif
endinterface

// File: rtl/mc_watchdog.sv
// rtl/mc_watchdog.sv - memory-wait cycle counter with clear, enable and limit compare
// clk, rst_n : clock, asynchronous active-low reset
// clr_i      : force count to zero
// en_i       : count one cycle
// hit_o      : current cycle is the LIMIT-th counted cycle
module mc_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !hit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count starts at 0 on the first waiting cycle, so LIMIT-1 marks the LIMIT-th cycle.
    assign hit_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - latches a multicycle instruction, walks its steps, stalls fetch, pulses done
// clk, rst_n : clock, asynchronous active-low reset
// bus        : multicycle_sequencer_if slave (instr_valid/instr/mem_ready in; decode, step, stall, mem_req, busy, done out)
// Optional MULTICYCLE_WATCHDOG_EN: bounds the memory wait to WDOG_LIMIT cycles and adds sticky bus.wdog_err.
module multicycle_sequencer
    import mc_pkg::*;
#(
    parameter int STEP_W     = 3
`ifdef MULTICYCLE_WATCHDOG_EN
  , parameter int WDOG_LIMIT = 15
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_sequencer_if.slave bus
);
    mc_state_e         state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] last_q, last_d;
    logic              wdog_trip;

`ifdef MULTICYCLE_WATCHDOG_EN
    logic wdog_hit;
    logic wdog_err_q;

    mc_watchdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != ST_MEM),
        .en_i  (state_q == ST_MEM),
        .hit_o (wdog_hit)
    );

    // A ready on the limit cycle still counts as a normal completion.
    assign wdog_trip = (state_q == ST_MEM) && !bus.mem_ready && wdog_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_err_q <= 1'b0;
        end else if (wdog_trip) begin
            wdog_err_q <= 1'b1;
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    assign wdog_trip = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        step_d   = step_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid && bus.instr[MC_MARK_BIT]) begin
                    opcode_d = bus.instr[7:0];
                    last_d   = STEP_W'(bus.instr[MC_LAST_LSB +: MC_LAST_W]);
                    step_d   = '0;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (step_q != last_q) begin
                    step_d = step_q + 1'b1;
                end else begin
                    state_d = opcode_q[MC_MEM_BIT] ? ST_MEM : ST_DONE;
                end
            end
            ST_MEM: begin
                if (bus.mem_ready || wdog_trip) begin
                    state_d = ST_DONE;
                end
            end
            // The instruction still held by fetch here is the one just retired.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= MC_OPCODE_RST;
            step_q   <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            step_q   <= step_d;
            last_q   <= last_d;
        end
    end

    assign bus.mc_opcode       = opcode_q;
    assign bus.step            = step_q;
    assign bus.stall           = (state_q == ST_EXEC) || (state_q == ST_MEM);
    assign bus.multicycle_flag = (state_q != ST_IDLE);
    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.mem_req         = (state_q == ST_MEM);
    assign bus.done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer with random instructions and memory waits
module tb_multicycle_sequencer;

    localparam int STEP_W     = 3;
    localparam int WDOG_LIMIT = 15;
`ifdef MULTICYCLE_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_sequencer_if #(.STEP_W(STEP_W)) bus ();

    multicycle_sequencer #(.STEP_W(STEP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] opc;
        int         n;
        int         stall_cyc;
        int         mem_cyc;
        int         gap;
        bit         wdog;
    } exp_t;

    exp_t exp_q[$];
    int   w_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: stall covers all EXEC steps 0..N plus every memory-wait cycle.
    function automatic exp_t model(input logic [8:0] ins, input int w, input int gap);
        exp_t e;
        e.opc  = ins[7:0];
        e.n    = int'(ins[2:0]);
        e.gap  = gap;
        e.wdog = 1'b0;
        if (!ins[3]) begin
            e.mem_cyc = 0;
        end else if (WDOG_ON && (w + 1 > WDOG_LIMIT)) begin
            e.mem_cyc = WDOG_LIMIT;
            e.wdog    = 1'b1;
        end else begin
            e.mem_cyc = w + 1;
        end
        e.stall_cyc = e.n + 1 + e.mem_cyc;
        return e;
    endfunction

    // Memory responder: raises mem_ready once mem_req has been seen for w cycles.
    int mcnt = 0;
    bit mprev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_ready = 1'b0;
            mcnt  = 0;
            mprev = 1'b0;
        end else begin
            if (mprev && !bus.mem_req && w_q.size() > 0) begin
                void'(w_q.pop_front());
                mcnt = 0;
            end
            if (bus.mem_req && w_q.size() > 0) begin
                bus.mem_ready = (mcnt == w_q[0]);
                mcnt++;
            end else begin
                bus.mem_ready = 1'b0;
            end
            mprev = bus.mem_req;
        end
    end

    // Monitor / scoreboard
    int         stall_acc = 0;
    int         mem_acc = 0;
    int         last_done = 0;
    logic [7:0] last_opc = 8'h00;
    bit         wd_exp = 1'b0;
    exp_t       me;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_acc = 0;
            mem_acc   = 0;
            last_opc  = 8'h00;
            wd_exp    = 1'b0;
        end else begin
            check("flag_eq_busy", bus.multicycle_flag, bus.busy);
            if (bus.stall) stall_acc++;
            if (bus.mem_req) mem_acc++;
            if (!bus.busy) begin
                check("opcode_hold_idle", bus.mc_opcode, last_opc);
`ifdef MULTICYCLE_WATCHDOG_EN
                check("wdog_err_idle", bus.wdog_err, wd_exp);
`endif
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    check("done_opcode", bus.mc_opcode, me.opc);
                    check("done_step", bus.step, me.n);
                    check("stall_cycles", stall_acc, me.stall_cyc);
                    check("mem_req_cycles", mem_acc, me.mem_cyc);
                    if (me.gap != 0) check("done_spacing", cyc - last_done, me.gap);
                    last_opc = me.opc;
                    wd_exp   = wd_exp | me.wdog;
`ifdef MULTICYCLE_WATCHDOG_EN
                    check("wdog_err_done", bus.wdog_err, wd_exp);
`endif
                end
                stall_acc = 0;
                mem_acc   = 0;
                last_done = cyc;
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (bus.busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [8:0] ins, input int w);
        wait_idle();
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        if (ins[8]) begin
            exp_q.push_back(model(ins, w, 0));
            if (ins[3]) w_q.push_back(w);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        if (!ins[8]) begin
            check("single_busy", bus.busy, 0);
            check("single_stall", bus.stall, 0);
            check("single_flag", bus.multicycle_flag, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        logic [8:0] ins;
        bus.instr       = 9'h000;
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.multicycle_flag, bus.mc_opcode, bus.step, bus.stall,
                                bus.mem_req, bus.busy, bus.done}, 0);
        rst_n = 1'b1;

        issue(9'h105, 0);
        issue(9'h10A, 3);
        issue(9'h005, 0);

        // Held instruction: samples at IDLE only, so 7 held cycles issue three times.
        wait_idle();
        bus.instr       = 9'h100;
        bus.instr_valid = 1'b1;
        exp_q.push_back(model(9'h100, 0, 0));
        exp_q.push_back(model(9'h100, 0, 3));
        exp_q.push_back(model(9'h100, 0, 3));
        repeat (7) @(negedge clk);
        bus.instr_valid = 1'b0;

        // Asynchronous reset in the middle of EXEC.
        issue(9'h105, 0);
        t = 0;
        while (!(bus.stall && bus.step == 3'd2) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("reach_step2_timeout", 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.multicycle_flag, bus.mc_opcode, bus.step, bus.stall,
                                      bus.mem_req, bus.busy, bus.done}, 0);
        exp_q.delete();
        w_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            ins = {($urandom_range(0, 3) != 0), 8'($urandom)};
            issue(ins, int'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef MULTICYCLE_WATCHDOG_EN
        issue(9'h108, 1000);
        issue(9'h101, 0);
`endif

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Sequencing controller for multicycle instructions in the i281 multicycle CPU. Sits between fetch and the multicycle decoder path:
- Detects a multicycle instruction and latches its 8-bit micro-opcode.
- Holds `multicycle_flag` high so decode traffic is steered to the multicycle opcode decoder.
- Stalls fetch/PC while it walks a step counter, with an optional memory handshake on the final step.
- Pulses `done` when the instruction retires.

## Interface
Parameters:
- `STEP_W`, 3, width of step counter; max steps 2^STEP_W.
- `WDOG_LIMIT`, 15, memory-wait cycles before watchdog trips (only with `MULTICYCLE_WATCHDOG_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: `instr` is valid this cycle.
- `instr` in 9: bit 8 = multicycle marker; [7:0] = opcode; [3] = final step needs memory; [2:0] = last step index N.
- `mem_ready` in 1: memory completed request.
- `multicycle_flag` out 1: route decode to multicycle path.
- `mc_opcode` out 8: latched opcode, stable for whole instruction.
- `step` out STEP_W: current step index.
- `stall` out 1: hold PC/fetch.
- `mem_req` out 1: memory request, level.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle retire pulse.
- `wdog_err` out 1: sticky watchdog error (only with macro).

## Operation
- States: IDLE, EXEC, MEM, DONE.
- IDLE:
  - `instr_valid && instr[8]`: latch `mc_opcode = instr[7:0]`, latch N = `instr[2:0]`, `step = 0`, go to EXEC.
  - `instr_valid && !instr[8]`: stay in IDLE; no outputs change (single-cycle path).
- EXEC:
  - While `step != N`: `step` increments by 1 each cycle.
  - When `step == N`: go to MEM if `mc_opcode[3]`, else go to DONE.
- MEM: `mem_req = 1`; on `mem_ready` go to DONE. `step` holds at N.
- DONE: `done = 1` for one cycle; go to IDLE. `instr_valid` during DONE is ignored, because it is the same held instruction.
- `instr_valid` is ignored in EXEC and MEM; upstream holds `instr` while `stall = 1`.
- Output decode:
  - `stall` = EXEC or MEM.
  - `multicycle_flag` = EXEC, MEM or DONE.
  - `busy` = state != IDLE.
- `step` never wraps: N ≤ 2^STEP_W−1, so the counter stops at N.
- `mc_opcode` holds its value after DONE until the next multicycle latch.
- Reset, asserted at any time including mid-instruction:
  - Immediately returns to IDLE.
  - `mc_opcode = 0`, `step = 0`, and all 1-bit outputs = 0.
  - The in-flight instruction is abandoned; no `done` pulse.

## Timing
- Detection to EXEC: 1 cycle (registered on the edge where IDLE samples the instruction).
- Non-memory instruction: EXEC for N+1 cycles, then DONE for 1 cycle. `stall` is high exactly N+1 cycles.
- Memory instruction: EXEC for N+1 cycles, MEM for W+1 cycles (W = cycles before `mem_ready`), then DONE.
- `mem_ready` already high on the first MEM cycle: MEM lasts 1 cycle.
- `stall` falls in DONE, so the PC advances on the DONE edge and the next instruction is presented in IDLE.
- Minimum spacing between multicycle instructions: N+3 cycles (EXEC N+1, DONE 1, IDLE 1).
- All outputs are decoded from registered state and counter; no combinational input-to-output paths except none.

## Configuration
- `MULTICYCLE_WATCHDOG_EN` defined:
  - A counter runs in MEM.
  - If it reaches WDOG_LIMIT without `mem_ready`: `wdog_err` is set (sticky until `rst_n`), `mem_req` drops, state goes to DONE, and `done` pulses.
  - `mem_ready` on the same cycle as the limit: normal completion; `wdog_err` is not set.
- Undefined: MEM waits indefinitely; the `wdog_err` port and the counter are absent.

## Structure
- Shared package/header `mc_pkg`: state encodings, field constants (`MC_MARK_BIT = 8`, `MC_MEM_BIT = 3`, `MC_LAST_LSB = 0`, `MC_LAST_W = 3`), reset values.
- One sub-module: `mc_watchdog` (cycle counter with clear, enable, and limit compare), instantiated only under the macro.

## Test plan
- Reset mid-EXEC (step = 2): all outputs go to 0 asynchronously; `done` never pulses.
- `instr = 9'h1_05` (N = 5, no memory): `stall` high 6 cycles, `step` 0→5, `done` pulse on the 7th cycle, `mc_opcode = 8'h05`.
- `instr = 9'h1_0A` (N = 2, memory), `mem_ready` after 3 cycles: `mem_req` high 4 cycles, then `done`; `step` holds at 2 in MEM.
- `instr = 9'h0_05` (single-cycle): `busy`, `stall` and `multicycle_flag` stay 0.
- Back-to-back `9'h1_00` instructions: second starts exactly 3 cycles after the first; the held instruction in DONE is not re-issued.
- With macro, `WDOG_LIMIT = 15`, `mem_ready` never asserted: `wdog_err` set after 15 MEM cycles, `done` pulses, `wdog_err` persists in IDLE until reset.
